dds_sweep_controller: RTL

Sequencer for the DDS phase-accumulator frequency control word (FSW). It steps FSW from a start value to a stop value in fixed increments and holds each value for a programmable dwell time. For each FSW it computes the output frequency with a sequential shift-add: freq = FSW × ACC_CLK_HZ / TABLE_SIZE. It sits between the switch/config logic and the phase accumulator, and also drives the frequency display.

---
 rtl/dds_sweep_controller.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
//   Steps the DDS frequency control word (fsw) from a start value to a stop
//   value in fixed increments. Each value is held for a programmable dwell.
//   For every point, the output frequency is computed as
//   freq = fsw * ACC_CLK_HZ >> TABLE_SIZE_LOG2, using one shift-add cycle
//   per fsw bit.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle pulse; begins a sweep when idle
//   stop          : aborts a sweep in progress (wins over start)
//   continuous    : 0 = single sweep, 1 = wrap to fsw_start forever
//   fsw_start/stop/step, dwell : sweep configuration, sampled at start
//   fsw, fsw_valid             : control word to the phase accumulator
//   freq_hz, freq_valid        : computed frequency for the display
//   busy, done, cfg_err        : status
module dds_sweep_controller #(
  parameter int ACC_CLK_HZ      = 10000,
  parameter int TABLE_SIZE_LOG2 = 8,
  parameter int DWELL_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [7:0]         fsw_start,
  input  logic [7:0]         fsw_stop,
  input  logic [7:0]         fsw_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [7:0]         fsw,
  output logic               fsw_valid,
  output logic [13:0]        freq_hz,
  output logic               freq_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [13:0] K = 14'(ACC_CLK_HZ);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_DWELL, S_STEP, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         cur_reg, cur_next;
  logic [7:0]         first_reg, first_next;
  logic [7:0]         last_reg, last_next;
  logic [7:0]         step_reg, step_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic               cont_reg, cont_next;
  logic [21:0]        acc_reg, acc_next;
  logic [2:0]         bit_reg, bit_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [7:0]         fsw_reg, fsw_next;
  logic [13:0]        freq_reg, freq_next;
  logic               fsw_valid_reg, fsw_valid_next;
  logic               freq_valid_reg, freq_valid_next;
  logic               done_reg, done_next;
  logic               cfg_err_reg, cfg_err_next;

  // Multiplier constant pre-shifted for each fsw bit position.
  logic [21:0] addend [8];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_addend
      assign addend[gi] = 22'(K) << gi;
    end
  endgenerate

  logic        cfg_ok;
  logic [21:0] sum;
  logic [8:0]  step_sum;

  assign cfg_ok = (fsw_start != 8'd0) && (fsw_step != 8'd0) &&
                  (fsw_start <= 8'd127) && (fsw_stop <= 8'd127) &&
                  (fsw_start <= fsw_stop);

  assign sum      = acc_reg + (cur_reg[bit_reg] ? addend[bit_reg] : 22'd0);
  // Nine bits, so that cur + step cannot wrap past the stop bound.
  assign step_sum = {1'b0, cur_reg} + {1'b0, step_reg};

  always_comb begin
    state_next      = state_reg;
    cur_next        = cur_reg;
    first_next      = first_reg;
    last_next       = last_reg;
    step_next       = step_reg;
    dwell_next      = dwell_reg;
    cont_next       = cont_reg;
    acc_next        = acc_reg;
    bit_next        = bit_reg;
    cnt_next        = cnt_reg;
    fsw_next        = fsw_reg;
    freq_next       = freq_reg;
    fsw_valid_next  = 1'b0;
    freq_valid_next = 1'b0;
    done_next       = 1'b0;
    cfg_err_next    = 1'b0;

    if (state_reg == S_IDLE) begin
      if (!stop && start) begin
        if (cfg_ok) begin
          cur_next   = fsw_start;
          first_next = fsw_start;
          last_next  = fsw_stop;
          step_next  = fsw_step;
          // A dwell of zero still holds the point for one cycle.
          dwell_next = (dwell == '0) ? DWELL_W'(1) : dwell;
          cont_next  = continuous;
          state_next = S_LOAD;
        end else begin
          cfg_err_next = 1'b1;
        end
      end
    end else if (stop) begin
      // Abort: outputs hold, and any partial product is simply dropped.
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_LOAD: begin
          fsw_next       = cur_reg;
          fsw_valid_next = 1'b1;
          acc_next       = 22'd0;
          bit_next       = 3'd0;
          state_next     = S_CALC;
        end
        S_CALC: begin
          acc_next = sum;
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            freq_next       = 14'(sum >> TABLE_SIZE_LOG2);
            freq_valid_next = 1'b1;
            cnt_next        = dwell_reg;
            state_next      = S_DWELL;
          end
        end
        S_DWELL: begin
          if (cnt_reg == DWELL_W'(1)) begin
            state_next = S_STEP;
          end else begin
            cnt_next = cnt_reg - DWELL_W'(1);
          end
        end
        S_STEP: begin
          if (step_sum <= {1'b0, last_reg}) begin
            cur_next   = step_sum[7:0];
            state_next = S_LOAD;
          end else if (cont_reg) begin
            cur_next   = first_reg;
            state_next = S_LOAD;
          end else begin
            state_next = S_DONE;
          end
        end
        S_DONE: begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cur_reg        <= 8'd0;
      first_reg      <= 8'd0;
      last_reg       <= 8'd0;
      step_reg       <= 8'd0;
      dwell_reg      <= '0;
      cont_reg       <= 1'b0;
      acc_reg        <= 22'd0;
      bit_reg        <= 3'd0;
      cnt_reg        <= '0;
      fsw_reg        <= 8'd0;
      freq_reg       <= 14'd0;
      fsw_valid_reg  <= 1'b0;
      freq_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      first_reg      <= first_next;
      last_reg       <= last_next;
      step_reg       <= step_next;
      dwell_reg      <= dwell_next;
      cont_reg       <= cont_next;
      acc_reg        <= acc_next;
      bit_reg        <= bit_next;
      cnt_reg        <= cnt_next;
      fsw_reg        <= fsw_next;
      freq_reg       <= freq_next;
      fsw_valid_reg  <= fsw_valid_next;
      freq_valid_reg <= freq_valid_next;
      done_reg       <= done_next;
      cfg_err_reg    <= cfg_err_next;
    end
  end

  assign fsw        = fsw_reg;
  assign fsw_valid  = fsw_valid_reg;
  assign freq_hz    = freq_reg;
  assign freq_valid = freq_valid_reg;
  assign busy       = (state_reg != S_IDLE);
  assign done       = done_reg;
  assign cfg_err    = cfg_err_reg;

endmodule
